// File: rtl/agc_pkg.sv
// agc_pkg: widths, gain type and arithmetic helpers shared by the multi-channel AGC.
// Sample/gain widths are fixed here; only the channel count is a module parameter.
package agc_pkg;
    localparam int W            = 12;
    localparam int TW           = 8;
    localparam int MW           = 8;
    localparam int EW           = 4;
    localparam int EXP_BIAS     = 8;
    localparam int LOG_WIN      = 4;
    localparam int STEP         = 16;
    localparam int HYST         = 4;
    localparam int LOCK_WINDOWS = 4;
    localparam int PW           = W + MW + 1;
    localparam int SW           = PW + (1 << EW) - 1;
    localparam int MAGW         = W + 1;
    localparam int ACCW         = MAGW + LOG_WIN;
    localparam int CW           = MAGW + 1;
    localparam int LCW          = $clog2(LOCK_WINDOWS + 1);
    localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (W - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO = SW'(-(1 << (W - 1)));

    typedef struct packed {
        logic [EW-1:0] exp;
        logic [MW-1:0] mant;
    } gain_t;

    typedef enum logic [1:0] {HOLD, UP, DOWN} dec_e;

    function automatic logic [W-1:0] scale(input logic signed [PW-1:0] p, input logic [EW-1:0] e);
        logic signed [SW-1:0] v;
        v = (SW'(p) <<< e) >>> (MW + EXP_BIAS);
        return v > SAT_HI ? SAT_HI[W-1:0] : v < SAT_LO ? SAT_LO[W-1:0] : v[W-1:0];
    endfunction

    function automatic logic [MAGW-1:0] mag(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [MAGW-1:0] x, y;
        x = MAGW'(a);
        y = MAGW'(b);
        return (x < 0 ? $unsigned(-x) : $unsigned(x)) + (y < 0 ? $unsigned(-y) : $unsigned(y));
    endfunction

    // Lower band edge floors at zero so a small threshold never wraps into a huge target.
    function automatic dec_e decide(input logic [MAGW-1:0] avg, input logic [TW-1:0] thr_in);
        logic [CW-1:0] thr, h;
        thr = CW'(thr_in) << (W - TW);
        h   = CW'(HYST) << (W - TW);
        return CW'(avg) > thr + h ? DOWN : CW'(avg) < (thr > h ? thr - h : '0) ? UP : HOLD;
    endfunction

    function automatic gain_t step_up(input gain_t g);
        logic [MW:0] s;
        s = {1'b0, g.mant} + (MW + 1)'(STEP);
        step_up = g;
        if (!s[MW]) step_up.mant = s[MW-1:0];
        else if (g.exp == '1) step_up.mant = '1;
        else begin
            step_up.mant = s[MW-1:0];
            step_up.exp  = g.exp + 1'b1;
        end
    endfunction

    function automatic gain_t step_down(input gain_t g);
        step_down = g;
        if (g.mant >= MW'(STEP)) step_down.mant = g.mant - MW'(STEP);
        else if (g.exp == '0) step_down.mant = '0;
        else begin
            step_down.mant = g.mant - MW'(STEP);
            step_down.exp  = g.exp - 1'b1;
        end
    endfunction
endpackage

// File: rtl/agc_gain_ch.sv
// agc_gain_ch: one I/Q channel -- three-stage gain pipeline, magnitude detector and gain register.
// With AGC_LOCK_DETECT_EN defined it also counts consecutive in-band windows and drives lock_o.
module agc_gain_ch
    import agc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_v_i,
    input  logic          s1_v_i,
    input  logic          s2_v_i,
    input  logic          out_v_i,
    input  logic          win_end_i,
    input  logic          gain_load_i,
    input  logic          freeze_i,
    input  logic [TW-1:0] threshold_i,
    input  logic [MW-1:0] init_mant_i,
    input  logic [EW-1:0] init_exp_i,
    input  logic [W-1:0]  in_i_i,
    input  logic [W-1:0]  in_q_i,
    output logic [W-1:0]  out_i_o,
    output logic [W-1:0]  out_q_o,
    output logic [MW-1:0] mant_o,
    output logic [EW-1:0] exp_o
`ifdef AGC_LOCK_DETECT_EN
    ,
    output logic          lock_o
`endif
);
    logic signed [W-1:0]  s1_i_q, s1_q_q, o_i_q, o_q_q;
    logic [MW-1:0]        s1_m_q;
    logic [EW-1:0]        s1_e_q, s2_e_q;
    logic signed [PW-1:0] s2_i_q, s2_q_q, fac;
    logic [ACCW-1:0]      acc_q, acc_d, acc_sum;
    logic [MAGW-1:0]      avg;
    gain_t                g_q, g_d, g_init, g_step;
    dec_e                 dec;

    assign g_init  = {init_exp_i, init_mant_i};
    assign fac     = PW'($signed({2'b01, s1_m_q}));
    assign acc_sum = acc_q + ACCW'(mag(o_i_q, o_q_q));
    assign avg     = MAGW'(acc_sum >> LOG_WIN);
    assign dec     = decide(avg, threshold_i);
    assign g_step  = dec == UP ? step_up(g_q) : dec == DOWN ? step_down(g_q) : g_q;
    assign g_d     = gain_load_i ? g_init : win_end_i && !freeze_i ? g_step : g_q;
    assign acc_d   = gain_load_i || win_end_i ? '0 : out_v_i ? acc_sum : acc_q;
    assign out_i_o = o_i_q;
    assign out_q_o = o_q_q;
    assign mant_o  = g_q.mant;
    assign exp_o   = g_q.exp;

    // Each stage advances only with its valid so a sample keeps the gain it was captured with.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_i_q <= '0;
            s1_q_q <= '0;
            s1_m_q <= '0;
            s1_e_q <= '0;
            s2_i_q <= '0;
            s2_q_q <= '0;
            s2_e_q <= '0;
            o_i_q  <= '0;
            o_q_q  <= '0;
            acc_q  <= '0;
            g_q    <= g_init;
        end else begin
            if (in_v_i) begin
                s1_i_q <= in_i_i;
                s1_q_q <= in_q_i;
                s1_m_q <= g_q.mant;
                s1_e_q <= g_q.exp;
            end
            if (s1_v_i) begin
                s2_i_q <= PW'(s1_i_q) * fac;
                s2_q_q <= PW'(s1_q_q) * fac;
                s2_e_q <= s1_e_q;
            end
            if (s2_v_i) begin
                o_i_q <= scale(s2_i_q, s2_e_q);
                o_q_q <= scale(s2_q_q, s2_e_q);
            end
            acc_q <= acc_d;
            g_q   <= g_d;
        end
    end

`ifdef AGC_LOCK_DETECT_EN
    logic [LCW-1:0] lc_q, lc_d;

    assign lock_o = lc_q == LCW'(LOCK_WINDOWS);
    assign lc_d   = gain_load_i ? '0 : !win_end_i ? lc_q : dec != HOLD ? '0 : lock_o ? lc_q : lc_q + 1'b1;

    always_ff @(posedge clk) begin
        lc_q <= rst ? '0 : lc_d;
    end
`endif
endmodule

// File: rtl/agc_mc.sv
// agc_mc: NCH-channel I/Q automatic gain control with a shared window counter and valid pipeline.
// Define AGC_LOCK_DETECT_EN to add the per-channel lock output.
module agc_mc
    import agc_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [NCH*W-1:0]  in_i,
    input  logic [NCH*W-1:0]  in_q,
    input  logic [TW-1:0]     threshold,
    input  logic [MW-1:0]     init_mantissa,
    input  logic [EW-1:0]     init_exp,
    input  logic              gain_load,
    input  logic              freeze,
    output logic              out_valid,
    output logic [NCH*W-1:0]  out_i,
    output logic [NCH*W-1:0]  out_q,
    output logic [NCH*MW-1:0] gain_mant,
    output logic [NCH*EW-1:0] gain_exp
`ifdef AGC_LOCK_DETECT_EN
    ,
    output logic [NCH-1:0]    lock
`endif
);
    logic [2:0]         v_q, v_d;
    logic [LOG_WIN-1:0] cnt_q, cnt_d;
    logic               win_end;

    assign v_d       = {v_q[1:0], in_valid};
    assign out_valid = v_q[2];
    assign win_end   = v_q[2] && cnt_q == '1;
    assign cnt_d     = gain_load ? '0 : v_q[2] ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        v_q   <= rst ? '0 : v_d;
        cnt_q <= rst ? '0 : cnt_d;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        agc_gain_ch u_ch (
            .clk         (clk),
            .rst         (rst),
            .in_v_i      (in_valid),
            .s1_v_i      (v_q[0]),
            .s2_v_i      (v_q[1]),
            .out_v_i     (v_q[2]),
            .win_end_i   (win_end),
            .gain_load_i (gain_load),
            .freeze_i    (freeze),
            .threshold_i (threshold),
            .init_mant_i (init_mantissa),
            .init_exp_i  (init_exp),
            .in_i_i      (in_i[c*W +: W]),
            .in_q_i      (in_q[c*W +: W]),
            .out_i_o     (out_i[c*W +: W]),
            .out_q_o     (out_q[c*W +: W]),
            .mant_o      (gain_mant[c*MW +: MW]),
            .exp_o       (gain_exp[c*EW +: EW])
`ifdef AGC_LOCK_DETECT_EN
            ,
            .lock_o      (lock[c])
`endif
        );
    end
endmodule
